fe_bank: RTL and testbench
==========================

// Module: fe_bank
// PURPOSE
//  Parametrised bank of NCH independent IN_W-input boolean functions (Fe
//  generalised), each defined by a 2^IN_W-bit truth table. One registered
//  evaluation stage behind a valid/ready handshake.
//  Feeds the DST40 round datapath: one transfer = one Fe layer for all channels.
// PARAMETERS
//  NCH      8        number of function channels (1..32)
//  IN_W     4        inputs per channel (2..6); table width TW = 2**IN_W
//  TBL_INIT 16'h53CA reset truth table (TW bits) for every channel; bit k = f(k)
// PORTS
//  clk       in   1          clock, all state on rising edge
//  rst_n     in   1          asynchronous reset, active low
//  in_valid  in   1          input word present
//  in_ready  out  1          bank can accept input this cycle
//  in_data   in   NCH*IN_W   channel c uses in_data[c*IN_W +: IN_W]
//  out_valid out  1          out_data holds an unconsumed result
//  out_ready in   1          downstream accepts result
//  out_data  out  NCH        out_data[c] = table[c][in_data channel c]
//  ld_valid  in   1          table load request (FE_BANK_LOAD_EN only)
//  ld_all    in   1          1: write ld_tbl to every channel, ignore ld_ch
//  ld_ch     in   clog2(NCH) target channel (min width 1)
//  ld_tbl    in   TW         new truth table
//  ld_err    out  1          one-cycle pulse: load rejected (ld_ch >= NCH)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, ld_err=0, all tables=TBL_INIT.
//    Async assert, clk-synchronous release; reset mid-transfer drops the result.
//  - in_ready = !out_valid | out_ready (combinational, no bubble).
//  - Input transfer: in_valid & in_ready at edge -> out_data updated, out_valid=1
//    next cycle. Latency 1 cycle, throughput 1 word/cycle.
//  - out_valid & !out_ready: out_data and out_valid held stable; in_ready=0.
//  - Output-only transfer (out_valid & out_ready & !in_valid): out_valid->0,
//    out_data keeps last value.
//  - Lookup: bit index = channel input as unsigned IN_W value; index 0 = LSB.
//  - Load (FE_BANK_LOAD_EN): ld_valid sampled every cycle, no ready; write
//    takes effect at that edge. Input transfer in the same cycle evaluates with
//    the OLD table; new table applies from next accepted input. Held results
//    are never recomputed.
//  - ld_all=1: all channels written, ld_ch ignored, ld_err stays 0.
//  - ld_all=0 & ld_ch >= NCH (NCH not power of 2): no table changes, ld_err=1
//    for exactly the following cycle. Back-to-back bad loads: ld_err stays 1.
//  - Multiple loads to one channel on consecutive cycles: last one wins.
// CONFIGURATION
//  FE_BANK_LOAD_EN defined: tables are registers (NCH*TW flops), runtime load
//    as above.
//  FE_BANK_LOAD_EN undefined: tables are constants TBL_INIT; ld_* inputs
//    ignored, ld_err tied 0; no table flops synthesised.
// TESTING
//  1 Reset, defaults: all 16 codes on every channel, out_ready=1 -> out_data[c]
//    follows 0x53CA (in=1 ->1, in=4 ->0, in=14 ->1, in=15 ->0), 1-cycle latency.
//  2 Backpressure: stream 4 words, out_ready=0 for 3 cycles after word 2 ->
//    in_ready=0, out_data frozen, no word lost/duplicated, order kept.
//  3 Load ch3 tbl=16'hFFFF while in_valid with ch3 code 0x4 -> that result
//    ch3=0 (old table), next word code 0x4 -> ch3=1; other channels unchanged.
//  4 ld_all=1 tbl=16'h0000 -> every out_data bit 0 for all codes; then
//    ld_ch=3 tbl=16'h8000 -> only ch3 code 15 gives 1.
//  5 NCH=6, ld_ch=7 -> ld_err pulses 1 cycle, all tables unchanged.
//  6 Reset asserted with out_valid=1 and loaded tables -> out_valid=0
//    immediately, tables back to TBL_INIT; macro undefined -> ld_* ignored.

Source files
------------

// File: rtl/fe_bank_if.sv
// fe_bank_if: input/output valid-ready handshakes plus the truth-table load port of fe_bank.
interface fe_bank_if #(parameter int NCH = 8, parameter int IN_W = 4);
    localparam int TW = 2 ** IN_W;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    logic                in_valid, in_ready, out_valid, out_ready;
    logic [NCH*IN_W-1:0] in_data;
    logic [NCH-1:0]      out_data;
    logic                ld_valid, ld_all, ld_err;
    logic [CW-1:0]       ld_ch;
    logic [TW-1:0]       ld_tbl;
    modport master (output in_valid, in_data, out_ready, ld_valid, ld_all, ld_ch, ld_tbl,
                    input in_ready, out_valid, out_data, ld_err);
    modport slave  (input in_valid, in_data, out_ready, ld_valid, ld_all, ld_ch, ld_tbl,
                    output in_ready, out_valid, out_data, ld_err);
endinterface

// File: rtl/fe_bank.sv
// fe_bank: NCH truth-table boolean functions behind one registered valid/ready stage.
// Define FE_BANK_LOAD_EN for runtime-loadable tables; otherwise tables are fixed at TBL_INIT.
module fe_bank #(
    parameter int NCH = 8,
    parameter int IN_W = 4,
    parameter logic [2**IN_W-1:0] TBL_INIT = 16'h53CA
) (
    input logic     clk,
    input logic     rst_n,
    fe_bank_if.slave bus
);
    localparam int TW = 2 ** IN_W;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    logic [NCH-1:0][TW-1:0] tbl;
    logic [NCH-1:0]         res, out_data;
    logic                   out_valid, ld_err;
`ifdef FE_BANK_LOAD_EN
    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);
    logic bad;
    assign bad = !bus.ld_all && {1'b0, bus.ld_ch} >= NCH_L;
    // Rejected loads touch nothing; the per-channel match keeps out-of-range indices harmless.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tbl    <= {NCH{TBL_INIT}};
            ld_err <= 1'b0;
        end else begin
            ld_err <= bus.ld_valid && bad;
            for (int c = 0; c < NCH; c++)
                if (bus.ld_valid && !bad && (bus.ld_all || bus.ld_ch == CW'(c)))
                    tbl[c] <= bus.ld_tbl;
        end
`else
    logic unused_ld;
    assign unused_ld = ^{bus.ld_valid, bus.ld_all, bus.ld_ch, bus.ld_tbl};
    assign tbl       = {NCH{TBL_INIT}};
    assign ld_err    = 1'b0;
`endif
    always_comb begin
        res = '0;
        for (int c = 0; c < NCH; c++)
            res[c] = tbl[c][bus.in_data[c*IN_W +: IN_W]];
    end
    assign bus.in_ready = !out_valid || bus.out_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (bus.in_valid && bus.in_ready) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.ld_err    = ld_err;
endmodule

// File: tb/tb_fe_bank.sv
// tb_fe_bank: directed plus random stimulus on a 6-channel bank, scoreboard-checked against a table model.
module tb_fe_bank;
    localparam int NCH = 6;
    localparam logic [15:0] INIT = 16'h53CA;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    fe_bank_if #(.NCH(NCH), .IN_W(4)) bus ();
    fe_bank #(.NCH(NCH), .IN_W(4), .TBL_INIT(INIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_pass = 0;
    logic [15:0] mt [NCH];
    logic [NCH-1:0] q [$];
    logic [NCH-1:0] last = '0;
    logic err_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [NCH-1:0] lookup(input logic [4*NCH-1:0] d);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = 1'((mt[c] >> d[c*4 +: 4]) & 16'd1);
        return r;
    endfunction

    // Reference model: decide each transfer from the handshake rules, then apply loads.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) mt[c] = INIT;
            q.delete();
            last = '0;
            err_exp = 0;
        end else begin
            if (bus.in_valid && (q.size() == 0 || bus.out_ready)) q.push_back(lookup(bus.in_data));
`ifdef FE_BANK_LOAD_EN
            err_exp = bus.ld_valid && !bus.ld_all && int'(bus.ld_ch) >= NCH;
            if (bus.ld_valid)
                for (int c = 0; c < NCH; c++)
                    if (bus.ld_all || int'(bus.ld_ch) == c) mt[c] = bus.ld_tbl;
`endif
        end

    // Monitor: compare what the DUT presents, pop on consumption.
    always @(negedge clk)
        if (rst_n) begin
            chk("in_ready", bus.in_ready, q.size() == 0 || bus.out_ready);
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data", bus.out_data, q[0]);
                last = q[0];
                if (bus.out_ready) void'(q.pop_front());
            end else chk("out_data_hold", bus.out_data, last);
            chk("ld_err", bus.ld_err, err_exp);
        end

    task automatic step(input logic iv, input logic [4*NCH-1:0] d, input logic ordy,
                        input logic lv, input logic la, input logic [2:0] lc, input logic [15:0] lt);
        bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
        bus.ld_valid = lv; bus.ld_all = la; bus.ld_ch = lc; bus.ld_tbl = lt;
        @(posedge clk); #1;
    endtask

    function automatic logic [4*NCH-1:0] all_code(input int k);
        return {NCH{4'(k)}};
    endfunction

    task automatic sweep();
        for (int k = 0; k < 16; k++) step(1, all_code(k), 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_ld_err", bus.ld_err, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        sweep();
        step(1, all_code(1), 1, 0, 0, 0, 0);
        step(1, all_code(2), 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, all_code(3), 0, 0, 0, 0, 0);
        step(1, all_code(3), 1, 0, 0, 0, 0);
        step(1, all_code(4), 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, all_code(4), 1, 1, 0, 3, 16'hFFFF);
        step(1, all_code(4), 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 5, 16'h0000);
        sweep();
        step(0, 0, 1, 1, 0, 3, 16'h8000);
        sweep();
        step(0, 0, 1, 1, 0, 7, 16'h1234);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, all_code(9), 1, 1, 0, 6, 16'hAAAA);
        step(1, all_code(15), 1, 1, 0, 7, 16'h5555);
        step(1, all_code(15), 1, 1, 0, 2, 16'h0F0F);
        step(1, all_code(8), 1, 1, 0, 2, 16'hF0F0);
        sweep();
        for (int i = 0; i < 400; i++) begin
            logic lv;
            lv = $urandom_range(0, 3) == 0;
            step(1'($urandom_range(0, 2) != 0), 24'($urandom), 1'($urandom_range(0, 2) != 0),
                 lv, 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
        end
        step(0, 0, 1, 1, 1, 0, 16'h6996);
        step(1, all_code(5), 0, 0, 0, 0, 0);
        step(1, all_code(6), 0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_out_data", bus.out_data, 0);
        @(posedge clk); #3 rst_n = 1;
        sweep();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0);
        chk("drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
